bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter and sequencer that shares the single Wishbone-style memory bus between instruction fetch (IF) and data access (MEM).
- Runs the multi-cycle bus handshake.
- Raises per-master stall requests toward the pipeline pause controller.
- Holds returned data while the consuming stage is stalled, and discards in-flight results on a pipeline flush.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
TIMEOUT_CYCLES, 255, bus watchdog limit in cycles (used only with BUS_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge)
stall_i  in  6  pipeline stall vector from pause controller; bit1=IF, bit4=MEM
flush_i  in  1  pipeline flush from pause controller
if_req_i  in  1  fetch request (level, held until served)
if_addr_i  in  ADDR_W  fetch address
if_inst_o  out  DATA_W  fetched instruction
stallreq_if_o  out  1  fetch-not-ready stall request (to stallreq_from_pc)
mem_req_i  in  1  data request (level)
mem_we_i  in  1  1=store, 0=load
mem_sel_i  in  DATA_W/8  byte enables
mem_addr_i  in  ADDR_W  data address
mem_wdata_i  in  DATA_W  store data
mem_rdata_o  out  DATA_W  load data
stallreq_mem_o  out  1  data-not-ready stall request (to stallreq_from_mem)
wb_cyc_o, wb_stb_o  out  1 each  bus cycle/strobe
wb_we_o  out  1  bus write enable
wb_sel_o  out  DATA_W/8  bus byte select
wb_adr_o  out  ADDR_W  bus address
wb_dat_o  out  DATA_W  bus write data
wb_dat_i  in  DATA_W  bus read data
wb_ack_i  in  1  bus acknowledge
bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- States: IDLE, BUSY_MEM, BUSY_IF, DONE_MEM, DONE_IF.
- Reset (rst==0 at edge):
  - state=IDLE; all wb_* outputs, if_inst_o, mem_rdata_o and bus_err_o = 0; internal flushed flag cleared.
  - A reset mid-transaction drops wb_cyc_o/wb_stb_o at that same edge.
- IDLE:
  - If flush_i=1, stay IDLE.
  - Else if mem_req_i=1, go to BUSY_MEM. Register wb_adr/we/sel/dat from the mem_* inputs; wb_cyc_o=wb_stb_o=1 from the next cycle.
  - Else if if_req_i=1, go to BUSY_IF with wb_we_o=0, wb_sel_o all ones, wb_adr_o=if_addr_i.
  - MEM has fixed priority over IF.
- BUSY_x:
  - Bus outputs stay stable until wb_ack_i=1.
  - On ack: drop cyc/stb at that edge and capture wb_dat_i into the selected read-data register (mem_rdata_o or if_inst_o; stores leave mem_rdata_o unchanged).
  - Then go to DONE_x, unless the flushed flag is set, in which case go to IDLE and discard the result.
- Flush while BUSY_x sets the flushed flag. The bus cycle is never aborted and always completes. The flag clears on entering IDLE.
- DONE_x:
  - The read-data register stays valid.
  - Stay in DONE_x while the consumer stage is stalled (stall_i[1] for IF, stall_i[4] for MEM) and flush_i=0.
  - Otherwise return to IDLE.
  - Read-data registers hold their values until the next capture.
- Stall requests (combinational):
  - stallreq_mem_o = mem_req_i && state!=DONE_MEM.
  - stallreq_if_o = if_req_i && state!=DONE_IF.
  - Both are forced to 0 during reset.
- Latency: request seen in IDLE at cycle 0 → cyc/stb high from cycle 1 → ack at cycle k≥1 → DONE at k+1.
  - Minimum 2 cycles of stall with a zero-wait slave.
- Simultaneous if_req_i and mem_req_i: serve MEM first. IF stays stalled and is served in the following IDLE cycle.
- A request that drops while BUSY still completes its bus cycle, then returns to DONE_x/IDLE as normal.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - A counter clears on entering BUSY_x and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop cyc/stb, load 0 into the selected read-data register, pulse bus_err_o for 1 cycle, and go to DONE_x (IDLE if flushed).
  - A simultaneous ack takes precedence over the timeout.
- Not defined: BUSY waits indefinitely; bus_err_o is tied to 0; no counter logic is present.

Test Plan:
- Reset with rst=0 while in BUSY_MEM → next edge: wb_cyc_o=0, state IDLE, all outputs 0.
- if_req_i=1, addr 0x00000100, slave acks in 3rd bus cycle with 0x24020005 → cyc high cycles 1-3; if_inst_o=0x24020005 and stallreq_if_o=0 at cycle 4.
- if_req_i and mem_req_i both 1 (load 0x80000010, data 0xDEADBEEF, 1-wait ack) → MEM served first, mem_rdata_o=0xDEADBEEF; IF bus cycle starts on the next IDLE; stallreq_if_o stays 1 throughout MEM service.
- Store (mem_we_i=1, sel=4'b0011, data 0x0000ABCD) → wb_we_o=1, wb_sel_o=4'b0011, wb_dat_o=0x0000ABCD stable until ack; mem_rdata_o unchanged.
- flush_i pulse during BUSY_IF → bus cycle completes on ack, arbiter returns to IDLE, if_inst_o not updated and no DONE_IF cycle; DONE_MEM with stall_i[4]=1 for 5 cycles holds mem_rdata_o constant.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks → cyc drops after 4 BUSY cycles, bus_err_o=1 for exactly 1 cycle, read data=0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master (IF, MEM) to one-slave Wishbone-style arbiter with stall requests and flush discard.
// Optional bus watchdog is compiled in with `define BUS_TIMEOUT_EN.
module bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_inst_o,
  output logic                stallreq_if_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                stallreq_mem_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  output logic                bus_err_o
);

  typedef enum logic [2:0] {IDLE, BUSY_MEM, BUSY_IF, DONE_MEM, DONE_IF} state_t;

  state_t state;
  logic   flushed;
  logic   kill;
  logic   busy;
  logic   tmo;

  assign busy = (state == BUSY_MEM) || (state == BUSY_IF);
  // A flush arriving in the same cycle as the ack must also discard the result.
  assign kill = flushed | flush_i;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  assign tmo = busy && !wb_ack_i && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt   <= '0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= tmo;
      if (!busy)          tmo_cnt <= '0;
      else if (!wb_ack_i) tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign tmo       = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      flushed     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= '0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      if_inst_o   <= '0;
      mem_rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          flushed <= 1'b0;
          if (!flush_i) begin
            if (mem_req_i) begin
              state    <= BUSY_MEM;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= mem_we_i;
              wb_sel_o <= mem_sel_i;
              wb_adr_o <= mem_addr_i;
              wb_dat_o <= mem_wdata_i;
            end else if (if_req_i) begin
              state    <= BUSY_IF;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b0;
              wb_sel_o <= '1;
              wb_adr_o <= if_addr_i;
            end
          end
        end
        BUSY_MEM, BUSY_IF: begin
          if (flush_i) flushed <= 1'b1;
          if (wb_ack_i || tmo) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (kill) begin
              state   <= IDLE;
              flushed <= 1'b0;
            end else if (state == BUSY_IF) begin
              state     <= DONE_IF;
              if_inst_o <= wb_ack_i ? wb_dat_i : '0;
            end else begin
              state <= DONE_MEM;
              // Stores keep the previous load data unless the watchdog fired.
              if (!wb_we_o || !wb_ack_i) mem_rdata_o <= wb_ack_i ? wb_dat_i : '0;
            end
          end
        end
        DONE_MEM: if (!(stall_i[4] && !flush_i)) state <= IDLE;
        DONE_IF:  if (!(stall_i[1] && !flush_i)) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign stallreq_mem_o = rst && mem_req_i && (state != DONE_MEM);
  assign stallreq_if_o  = rst && if_req_i  && (state != DONE_IF);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; the slave is driven by hand step by step.
module tb_bus_arbiter;
`ifdef BUS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_inst_o;
  logic        stallreq_if_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        stallreq_mem_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o),
    .stallreq_if_o(stallreq_if_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .stallreq_mem_o(stallreq_mem_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; stall_i = '0; flush_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = '0;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = '0; mem_wdata_i = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0;

    // Reset with requests asserted
    tick(); tick();
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_inst", if_inst_o, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_sreq_if", stallreq_if_o, 0);
    chk("rst_sreq_mem", stallreq_mem_o, 0);
    if_req_i = 1'b0; mem_req_i = 1'b0; rst = 1'b1;
    tick();
    chk("idle_cyc", wb_cyc_o, 0);

    // Instruction fetch, ack in third bus cycle
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    #1 chk("if_sreq_idle", stallreq_if_o, 1);
    tick();
    chk("if_c1_cyc", wb_cyc_o, 1);
    chk("if_c1_stb", wb_stb_o, 1);
    chk("if_c1_adr", wb_adr_o, 32'h0000_0100);
    chk("if_c1_sel", wb_sel_o, 4'hF);
    chk("if_c1_we", wb_we_o, 0);
    chk("if_c1_sreq", stallreq_if_o, 1);
    tick();
    chk("if_c2_cyc", wb_cyc_o, 1);
    tick();
    chk("if_c3_cyc", wb_cyc_o, 1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h2402_0005;
    tick();
    chk("if_c4_cyc", wb_cyc_o, 0);
    chk("if_c4_inst", if_inst_o, 32'h2402_0005);
    chk("if_c4_sreq", stallreq_if_o, 0);
    wb_ack_i = 1'b0; if_req_i = 1'b0;
    tick();

    // Simultaneous requests: MEM load first, then IF
    if_req_i = 1'b1; if_addr_i = 32'h0000_0104;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h8000_0010;
    tick();
    chk("both_adr", wb_adr_o, 32'h8000_0010);
    chk("both_cyc", wb_cyc_o, 1);
    chk("both_sreq_if1", stallreq_if_o, 1);
    chk("both_sreq_mem1", stallreq_mem_o, 1);
    tick();
    chk("both_wait_cyc", wb_cyc_o, 1);
    chk("both_sreq_if2", stallreq_if_o, 1);
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    tick();
    chk("both_rdata", mem_rdata_o, 32'hDEAD_BEEF);
    chk("both_done_cyc", wb_cyc_o, 0);
    chk("both_sreq_mem_done", stallreq_mem_o, 0);
    chk("both_sreq_if3", stallreq_if_o, 1);
    chk("both_inst_keep", if_inst_o, 32'h2402_0005);
    wb_ack_i = 1'b0; mem_req_i = 1'b0;
    tick();
    chk("both_idle_cyc", wb_cyc_o, 0);
    chk("both_sreq_if4", stallreq_if_o, 1);
    tick();
    chk("both_if_cyc", wb_cyc_o, 1);
    chk("both_if_adr", wb_adr_o, 32'h0000_0104);
    wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
    tick();
    chk("both_if_inst", if_inst_o, 32'h1111_1111);
    wb_ack_i = 1'b0; if_req_i = 1'b0;
    tick();

    // Store: bus outputs stable until ack, load data untouched
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h8000_0020; mem_wdata_i = 32'h0000_ABCD;
    tick();
    chk("st_we", wb_we_o, 1);
    chk("st_sel", wb_sel_o, 4'b0011);
    chk("st_dat", wb_dat_o, 32'h0000_ABCD);
    mem_wdata_i = 32'h1234_5678; mem_sel_i = 4'hF; mem_addr_i = 32'h0;
    tick();
    chk("st_dat_hold", wb_dat_o, 32'h0000_ABCD);
    chk("st_sel_hold", wb_sel_o, 4'b0011);
    chk("st_adr_hold", wb_adr_o, 32'h8000_0020);
    wb_ack_i = 1'b1; wb_dat_i = 32'h5555_5555;
    tick();
    chk("st_cyc_drop", wb_cyc_o, 0);
    chk("st_rdata_keep", mem_rdata_o, 32'hDEAD_BEEF);
    wb_ack_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    tick();

    // Flush while IDLE blocks a new bus cycle
    mem_req_i = 1'b1; mem_addr_i = 32'h8000_0030; flush_i = 1'b1;
    tick();
    chk("fl_idle_cyc", wb_cyc_o, 0);
    mem_req_i = 1'b0; flush_i = 1'b0;

    // Flush during BUSY_IF: cycle completes, result dropped, no DONE_IF
    if_req_i = 1'b1; if_addr_i = 32'h0000_0200;
    tick();
    chk("fl_busy_cyc", wb_cyc_o, 1);
    flush_i = 1'b1;
    tick();
    chk("fl_not_aborted", wb_cyc_o, 1);
    flush_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h9999_9999;
    tick();
    chk("fl_cyc_drop", wb_cyc_o, 0);
    chk("fl_inst_keep", if_inst_o, 32'h1111_1111);
    chk("fl_no_done", stallreq_if_o, 1);
    wb_ack_i = 1'b0; if_req_i = 1'b0;
    tick();

    // DONE_MEM held by stall_i[4] for 5 cycles
    mem_req_i = 1'b1; mem_addr_i = 32'h8000_0040;
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D; stall_i = 6'b01_0000;
    tick();
    chk("hold_rdata0", mem_rdata_o, 32'hCAFE_F00D);
    wb_ack_i = 1'b0; wb_dat_i = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rdata", mem_rdata_o, 32'hCAFE_F00D);
      chk("hold_sreq_mem", stallreq_mem_o, 0);
      chk("hold_cyc", wb_cyc_o, 0);
    end
    stall_i = '0;
    tick();
    chk("hold_release_sreq", stallreq_mem_o, 1);
    mem_req_i = 1'b0;
    tick();

`ifdef BUS_TIMEOUT_EN
    // Watchdog: slave never acks
    mem_req_i = 1'b1; mem_addr_i = 32'h8000_0050;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tmo_cyc_busy", wb_cyc_o, 1);
      chk("tmo_err_low", bus_err_o, 0);
    end
    tick();
    chk("tmo_cyc_drop", wb_cyc_o, 0);
    chk("tmo_err_pulse", bus_err_o, 1);
    chk("tmo_rdata_zero", mem_rdata_o, 0);
    mem_req_i = 1'b0;
    tick();
    chk("tmo_err_once", bus_err_o, 0);
    tick();
`endif

    // Reset in the middle of BUSY_MEM
    mem_req_i = 1'b1; mem_addr_i = 32'h8000_0060;
    tick();
    chk("mrst_busy_cyc", wb_cyc_o, 1);
    rst = 1'b0;
    tick();
    chk("mrst_cyc", wb_cyc_o, 0);
    chk("mrst_stb", wb_stb_o, 0);
    chk("mrst_adr", wb_adr_o, 0);
    chk("mrst_rdata", mem_rdata_o, 0);
    chk("mrst_inst", if_inst_o, 0);
    chk("mrst_sreq_mem", stallreq_mem_o, 0);
    rst = 1'b1; mem_req_i = 1'b0;
    tick();
    chk("mrst_idle_cyc", wb_cyc_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
